stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the stopwatch time counters (seconds_counter and later stages).
//  Turns start/stop/reset button levels into single events, runs the IDLE/RUNNING/PAUSED FSM and
//  drives the 2-bit state bus. Prescales clk to a 1-cycle 'tick' per second.
//  Counters advance only on tick and clear on the 'clear' pulse.
// PARAMETERS
//  CLK_DIV  50_000_000  clk cycles per tick (>=2); prescaler width PRESC_W = $clog2(CLK_DIV)
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  start_btn  in   1  start/resume request; level, already synchronised to clk
//  stop_btn   in   1  pause request; level, synchronised
//  reset_btn  in   1  clear request; level, synchronised
//  state      out  2  00 IDLE, 01 RUNNING, 10 PAUSED (11 never driven)
//  tick       out  1  1-cycle pulse, one per CLK_DIV cycles spent in RUNNING
//  clear      out  1  1-cycle pulse; time counters must zero
//  lap_hold   out  1  display freeze (only with STOPWATCH_LAP_EN, else tied 0)
// BEHAVIOUR
//  - rst_n low (async): state=00, tick=0, clear=0, lap_hold=0, prescaler=0, button history regs=0.
//  - Edge detect per button: ev_x = x_btn & ~x_btn_q. x_btn_q <= x_btn every cycle.
//    A held button gives exactly one event. A button high at reset release fires on the first edge.
//  - Event priority in one cycle: reset > stop > start. Only the winner is acted on.
//  - FSM, updates on the clk edge that samples the event (input->state latency 1 cycle):
//      IDLE    --start--> RUNNING ; stop ignored
//      RUNNING --stop---> PAUSED  ; start ignored
//      PAUSED  --start--> RUNNING ; stop ignored
//      any     --reset--> IDLE    ; reset in IDLE still re-issues clear
//  - clear: registered. High for exactly the cycle after a reset event is accepted,
//    i.e. coincident with the first IDLE cycle.
//  - Prescaler, 0..CLK_DIV-1:
//      RUNNING: increments each cycle and wraps to 0
//      PAUSED:  holds (fractional second preserved across pause/resume)
//      IDLE or reset event: forced to 0
//  - tick: registered. Set on the cycle after the prescaler is at CLK_DIV-1 while state==RUNNING
//    and no stop/reset event is accepted that cycle.
//    The first tick after start comes CLK_DIV cycles after state goes 01. Never high with clear.
//  - Stop and wrap in the same cycle: stop wins, no tick. The prescaler still wraps to 0 and then holds.
//  - Unreachable state 11: next state IDLE, with a clear pulse.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//    - In RUNNING, a start event toggles lap_hold; the FSM is unchanged and counting continues.
//    - lap_hold forced 0 on leaving RUNNING, on reset event, and on rst_n.
//  Not defined: lap_hold is constant 0; start in RUNNING is ignored; no extra flops.
// TESTING  (CLK_DIV=4, cycle numbers counted from the clk edge that samples the event)
//  1. rst_n release, start pulse -> state=01 at edge 0; tick high after edges 4, 8, 12; clear stays 0.
//  2. Start, stop 2 cycles later -> state=10, prescaler holds at 2, no tick for 20 cycles.
//     Then start -> state=01 and the next tick lands 2 cycles later.
//  3. reset_btn while RUNNING mid-count -> state=00, clear high exactly 1 cycle, prescaler 0, no tick.
//     Repeat with start+stop+reset together in PAUSED -> same result (priority).
//  4. start_btn held high 30 cycles in IDLE -> one transition to 01 only.
//     Then stop_btn held -> one transition to 10. stop in IDLE -> state stays 00.
//  5. rst_n low mid-RUNNING, between edges -> state/tick/clear 0 immediately, without waiting for clk.
//     After release, start needs a fresh rising edge unless the button is already high.
//  6. LAP_EN: RUNNING, start -> lap_hold=1 and ticks continue; start again -> 0.
//     Set lap_hold=1, then stop -> 0. Without the macro, lap_hold stays 0 throughout.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear sequencer.
// Turns start/stop/reset button levels into single-cycle events and runs the
// IDLE/RUNNING/PAUSED FSM. It also prescales clk into a one-cycle tick per CLK_DIV
// cycles spent running, and issues a one-cycle clear pulse for the time counters.
// Optional feature: define STOPWATCH_LAP_EN to let a start event in RUNNING toggle lap_hold.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       reset_btn,
  output logic [1:0] state,
  output logic       tick,
  output logic       clear,
  output logic       lap_hold
);

  localparam int unsigned PRESC_W = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRunning = 2'b01,
    StPaused  = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic                 clear_q, clear_d;
  logic                 start_q, stop_q, reset_q;
  logic                 ev_start, ev_stop, ev_reset;
  logic                 win_start, win_stop, win_reset;

  // Rising-edge detection; a button already high at reset release fires on the first edge.
  assign ev_start = start_btn & ~start_q;
  assign ev_stop  = stop_btn  & ~stop_q;
  assign ev_reset = reset_btn & ~reset_q;

  // Only the highest-priority event of a cycle is acted on: reset > stop > start.
  assign win_reset = ev_reset;
  assign win_stop  = ev_stop & ~ev_reset;
  assign win_start = ev_start & ~ev_stop & ~ev_reset;

  // Button history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= start_btn;
      stop_q  <= stop_btn;
      reset_q <= reset_btn;
    end
  end

  // FSM, prescaler and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
    end
  end

  // Next-state, prescaler and pulse decode; the prescaler follows the current state so a
  // stop coinciding with a wrap still wraps to 0 before holding.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    case (state_q)
      StIdle: begin
        presc_d = '0;
        if (win_start) state_d = StRunning;
      end
      StRunning: begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        tick_d  = (presc_q == PRESC_MAX) & ~win_stop;
        if (win_stop) state_d = StPaused;
      end
      StPaused: begin
        if (win_start) state_d = StRunning;
      end
      default: begin
        state_d = StIdle;
        presc_d = '0;
        clear_d = 1'b1;
      end
    endcase
    if (win_reset) begin
      state_d = StIdle;
      presc_d = '0;
      tick_d  = 1'b0;
      clear_d = 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_q, lap_d;

  // Lap toggles only while staying in RUNNING; anything else forces it low.
  always_comb begin
    lap_d = 1'b0;
    if (state_q == StRunning && state_d == StRunning) lap_d = lap_q ^ win_start;
  end

  // Lap freeze register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lap_q <= 1'b0;
    else        lap_q <= lap_d;
  end

  assign lap_hold = lap_q;
`else
  assign lap_hold = 1'b0;
`endif

  assign state = state_q;
  assign tick  = tick_q;
  assign clear = clear_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with CLK_DIV=4: directed scenarios plus random
// button traffic, checked against a behavioural model of the stopwatch rules.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       reset_btn = 1'b0;
  logic [1:0] state;
  logic       tick;
  logic       clear;
  logic       lap_hold;

  stopwatch_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_btn(start_btn),
    .stop_btn (stop_btn),
    .reset_btn(reset_btn),
    .state    (state),
    .tick     (tick),
    .clear    (clear),
    .lap_hold (lap_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       tk;
    logic       cl;
    logic       lh;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Model: mode 0 idle, 1 running, 2 paused; frac = cycles into the current second.
  int   m_mode;
  int   m_frac;
  bit   m_lap;
  bit   p_s, p_p, p_r;

  task automatic model_reset();
    m_mode = 0; m_frac = 0; m_lap = 0;
    p_s = 0; p_p = 0; p_r = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit r, output exp_t e);
    bit es, ep, er, tk, cl;
    int nmode;
    es = s && !p_s; ep = p && !p_p; er = r && !p_r;
    p_s = s; p_p = p; p_r = r;
    tk = 0; cl = 0; nmode = m_mode;
    if (er) begin
      nmode = 0; cl = 1; m_frac = 0; m_lap = 0;
    end else begin
      if (m_mode == 1) begin
        tk = (m_frac == CLK_DIV - 1) && !ep;
        m_frac = (m_frac + 1) % CLK_DIV;
      end else if (m_mode == 0) begin
        m_frac = 0;
      end
      if (ep) begin
        if (m_mode == 1) begin nmode = 2; m_lap = 0; end
      end else if (es) begin
        if (m_mode != 1) nmode = 1;
`ifdef STOPWATCH_LAP_EN
        else m_lap = !m_lap;
`endif
      end
    end
    m_mode = nmode;
    e.st = 2'(m_mode); e.tk = tk; e.cl = cl; e.lh = m_lap;
  endtask

  // Drive one clock's worth of button levels; the expectation is queued at the edge.
  task automatic cycle(input bit s, input bit p, input bit r);
    exp_t e;
    start_btn = s; stop_btn = p; reset_btn = r;
    model_step(s, p, r, e);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic hold(input bit s, input bit p, input bit r, input int n);
    for (int i = 0; i < n; i++) cycle(s, p, r);
  endtask

  task automatic check_now(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got {st,tick,clr,lap}=%b want %b", name, got, want);
    end
  endtask

  // Monitor: compare every presented output against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({state, tick, clear, lap_hold} !== e) begin
          errors++;
          $display("FAIL out t=%0t got st=%b tick=%b clr=%b lap=%b want st=%b tick=%b clr=%b lap=%b",
                   $time, state, tick, clear, lap_hold, e.st, e.tk, e.cl, e.lh);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_now("reset_values", {state, tick, clear, lap_hold}, 5'b0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Start and free-run: ticks after edges 4, 8, 12.
    cycle(1, 0, 0);
    hold(0, 0, 0, 14);
    // Back to idle, then start / stop two cycles later, long pause, resume.
    cycle(0, 0, 1);
    hold(0, 0, 0, 2);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    hold(0, 0, 0, 20);
    cycle(1, 0, 0);
    hold(0, 0, 0, 6);
    // Reset mid-count, then all three buttons together while paused.
    cycle(0, 0, 1);
    hold(0, 0, 0, 3);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(1, 1, 1);
    hold(0, 0, 0, 3);
    // Held buttons give one event each; stop in idle is ignored.
    hold(1, 0, 0, 30);
    hold(0, 1, 0, 10);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    hold(0, 1, 0, 5);
    cycle(0, 0, 0);
    // Lap toggling while running, then stop clears lap.
    cycle(1, 0, 0);
    hold(0, 0, 0, 3);
    cycle(1, 0, 0);
    hold(0, 0, 0, 6);
    cycle(1, 0, 0);
    hold(0, 0, 0, 2);
    cycle(1, 0, 0);
    hold(0, 0, 0, 2);
    cycle(0, 1, 0);
    hold(0, 0, 0, 3);

    // Asynchronous reset between edges while running; start held across release.
    cycle(1, 0, 0);
    hold(0, 0, 0, 5);
    @(negedge clk); #2;
    rst_n = 1'b0;
    start_btn = 1'b1;
    #1;
    check_now("async_reset", {state, tick, clear, lap_hold}, 5'b0);
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 0, 0);
    hold(1, 0, 0, 9);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 4);
    end

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
